seven_seg_scanner: RTL and testbench

Time-multiplexed scan controller for a NUM_DIGITS-digit common-anode seven-segment display. Holds a packed BCD word and cycles through the digits, presenting one BCD nibble at a time on `bcd` for the downstream BCD-to-segment decoder and driving the matching active-low anode line. A blanking interval at the start of each digit slot prevents ghosting. New display values are applied only at frame boundaries, so a frame never mixes old and new digits.

---
 rtl/seven_seg_pkg.sv | 8 +
 rtl/scan_prescaler.sv | 30 +++
 rtl/seven_seg_scanner.sv | 91 +++++++++
 tb/tb_seven_seg_scanner.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: shared scan-state type, blank code and width helper for the seven-segment scanner
package seven_seg_pkg;
    typedef enum logic {BLANK, DRIVE} scan_state_e;
    localparam logic [3:0] BCD_BLANK = 4'hF;
    function automatic int cw(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/scan_prescaler.sv
// scan_prescaler: per-slot cycle counter with slot-start (wrap) and end-of-blanking strobes
module scan_prescaler
    import seven_seg_pkg::*;
#(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 1000,
    localparam int CW = cw(REFRESH_DIV)
) (
    input  logic clk,
    input  logic rst_n,
    output logic first_o,
    output logic wrap_o,
    output logic blank_done_o
);
    logic [CW-1:0] cnt_q;
    logic          run_q;
    assign first_o      = !run_q;
    // the first clocked cycle out of reset also starts a slot so the scan opens at counter 0
    assign wrap_o       = !run_q || cnt_q == CW'(REFRESH_DIV - 1);
    assign blank_done_o = run_q && BLANK_CYCLES != 0 && cnt_q == CW'(BLANK_CYCLES - 1);
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
            cnt_q <= wrap_o ? '0 : cnt_q + 1'b1;
        end
    end
endmodule

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: multiplexed common-anode digit scanner with frame-aligned display updates
// SEVEN_SEG_LZ_SUPPRESS_EN compiles in leading-zero suppression.
module seven_seg_scanner
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic                    load,
    output logic [3:0]              bcd,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_start
);
    localparam int IW = cw(NUM_DIGITS);
    localparam int DW = 4 * NUM_DIGITS;

    if (NUM_DIGITS < 2 || NUM_DIGITS > 8) begin : g_bad_digits
        $error("NUM_DIGITS must be in 2..8");
    end
    if (REFRESH_DIV < 2) begin : g_bad_div
        $error("REFRESH_DIV must be at least 2");
    end
    if (BLANK_CYCLES < 0 || BLANK_CYCLES >= REFRESH_DIV) begin : g_bad_blank
        $error("BLANK_CYCLES must be in 0..REFRESH_DIV-1");
    end

    logic                  wrap, first, blank_done, boundary, sup;
    logic [IW-1:0]         idx_q, idx_d;
    logic [DW-1:0]         disp_q, disp_d, pend_q, pend_d;
    logic                  pending_valid_q, pending_valid_d;
    scan_state_e           state_q, state_d;
    logic [NUM_DIGITS-1:0] an_q;
    logic [3:0]            bcd_q;
    logic                  frame_start_q;

    scan_prescaler #(
        .REFRESH_DIV (REFRESH_DIV),
        .BLANK_CYCLES(BLANK_CYCLES)
    ) u_prescaler (
        .clk         (clk),
        .rst_n       (rst_n),
        .first_o     (first),
        .wrap_o      (wrap),
        .blank_done_o(blank_done)
    );

    always_comb begin
        idx_d           = !wrap ? idx_q : (first || idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
        boundary        = wrap && idx_d == '0;
        disp_d          = !boundary ? disp_q : load ? digits_in : pending_valid_q ? pend_q : disp_q;
        pend_d          = load ? digits_in : pend_q;
        pending_valid_d = !boundary && (load || pending_valid_q);
        state_d         = wrap ? (BLANK_CYCLES == 0 ? DRIVE : BLANK) : blank_done ? DRIVE : state_q;
        sup             = 1'b0;
`ifdef SEVEN_SEG_LZ_SUPPRESS_EN
        sup = idx_d != '0;
        for (int j = 0; j < NUM_DIGITS; j++)
            if (j >= int'(idx_d) && disp_d[4*j +: 4] != 4'h0) sup = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q           <= '0;
            disp_q          <= '0;
            pend_q          <= '0;
            pending_valid_q <= 1'b0;
            state_q         <= BLANK;
            an_q            <= '1;
            bcd_q           <= BCD_BLANK;
            frame_start_q   <= 1'b0;
        end else begin
            idx_q           <= idx_d;
            disp_q          <= disp_d;
            pend_q          <= pend_d;
            pending_valid_q <= pending_valid_d;
            state_q         <= state_d;
            an_q            <= (state_d == DRIVE && !sup) ? ~(NUM_DIGITS'(1) << idx_d) : '1;
            bcd_q           <= !wrap ? bcd_q : sup ? BCD_BLANK : disp_d[4*idx_d +: 4];
            frame_start_q   <= boundary;
        end
    end

    assign an          = an_q;
    assign bcd         = bcd_q;
    assign frame_start = frame_start_q;
endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb_seven_seg_scanner: randomized scoreboard bench against a frame-level display model
module tb_seven_seg_scanner;
    localparam int ND = 4, RD = 8, BC = 2, FR = ND * RD;

    typedef struct packed {
        logic [3:0] an;
        logic [3:0] bcd;
        logic       fs;
        int         cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [15:0] digits_in = '0;
    logic [3:0]  bcd;
    logic [3:0]  an;
    logic        frame_start;

    int   checks = 0, failures = 0;
    exp_t q[$];
    exp_t m;
    int          k = 0;
    logic        r_prev = 1'b0;
    logic [15:0] disp = '0, pend = '0;
    logic        pv = 1'b0;

    seven_seg_scanner #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
        .clk(clk), .rst_n(rst_n), .digits_in(digits_in), .load(load),
        .bcd(bcd), .an(an), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // expected outputs of running cycle kk while the frame shows value d
    function automatic exp_t model_out(input int kk, input logic [15:0] d);
        exp_t e;
        int pos, dg;
        logic s;
        pos = kk % RD;
        dg  = (kk / RD) % ND;
        s   = 1'b0;
`ifdef SEVEN_SEG_LZ_SUPPRESS_EN
        s = dg != 0 && (d >> (4 * dg)) == 16'h0;
`endif
        e.an  = (pos >= BC && !s) ? ~(4'b0001 << dg) : 4'hF;
        e.bcd = s ? 4'hF : 4'((d >> (4 * dg)) & 16'hF);
        e.fs  = (kk % FR) == 0;
        e.cyc = kk;
        return e;
    endfunction

    task automatic tick(input logic r, input logic ld, input logic [15:0] v);
        exp_t e;
        @(posedge clk);
        #1;
        if (!r_prev) begin
            e = '{an: 4'hF, bcd: 4'hF, fs: 1'b0, cyc: -1};
            k = 0;
        end else begin
            if (k % FR == 0 && pv) begin
                disp = pend;
                pv   = 1'b0;
            end
            e = model_out(k, disp);
            k++;
        end
        q.push_back(e);
        rst_n     = r;
        load      = ld && r;
        digits_in = v;
        if (r && ld) begin
            pend = v;
            pv   = 1'b1;
        end
        if (!r) begin
            pv   = 1'b0;
            disp = '0;
        end
        r_prev = r;
    endtask

    task automatic run_to(input int target);
        while (k < target) tick(1'b1, 1'b0, 16'h0);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", nm, act, want);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            m = q.pop_front();
            checks++;
            if ({an, bcd, frame_start} !== {m.an, m.bcd, m.fs}) begin
                failures++;
                $display("FAIL scan cyc=%0d an=%b want=%b bcd=%h want=%h fs=%b want=%b",
                         m.cyc, an, m.an, bcd, m.bcd, frame_start, m.fs);
            end
        end
    end

    initial begin
        logic [15:0] v;
        repeat (3) tick(1'b0, 1'b0, 16'h0);
        tick(1'b1, 1'b0, 16'h0);
        run_to(1);
        tick(1'b1, 1'b1, 16'h1234);
        run_to(40);
        tick(1'b1, 1'b1, 16'h5678);
        run_to(50);
        tick(1'b1, 1'b1, 16'h9999);
        tick(1'b1, 1'b0, 16'h0);
        chk("pending_set_mid_frame", 32'(dut.pending_valid_q), 32'd1);
        run_to(FR * 3 - 1);
        tick(1'b1, 1'b1, 16'h0040);
        tick(1'b1, 1'b0, 16'h0);
        chk("pending_clear_boundary_load", 32'(dut.pending_valid_q), 32'd0);
        run_to(FR * 4 - 1);
        tick(1'b1, 1'b1, 16'h0000);
        run_to(150);
        tick(1'b1, 1'b1, 16'h1234);
        run_to(161);
        tick(1'b1, 1'b1, 16'h8765);
        run_to(180);
        tick(1'b0, 1'b0, 16'h0);
        tick(1'b1, 1'b0, 16'h0);
        chk("reset_index", 32'(dut.idx_q), 32'd0);
        chk("reset_pending", 32'(dut.pending_valid_q), 32'd0);
        run_to(FR * 2);
        for (int i = 0; i < 640; i++) begin
            for (int n = 0; n < 4; n++)
                v[4*n +: 4] = ($urandom_range(1) == 0) ? 4'h0 : 4'($urandom_range(15));
            tick(1'b1, $urandom_range(15) == 0, v);
        end
        run_to(k + FR + 1);
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
